// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider-sharing arbiter: FSM state encoding,
// default operand width and the divider error code.
package div_arb_pkg;

    localparam int DW_DEFAULT = 4;

    // Value of the divider's error_out when the divisor was zero.
    localparam logic DIV_BY_ZERO = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND_A = 3'd1;
    localparam logic [2:0] ST_SEND_B = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;
    localparam logic [2:0] ST_TO_RST = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SEND_A = ST_SEND_A,
        SEND_B = ST_SEND_B,
        WAIT   = ST_WAIT,
        RESP   = ST_RESP,
        TO_RST = ST_TO_RST
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around, returned as one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int j;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        any = |req;
        // Walk from the farthest offset down so the nearest match to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// Shares one serial signed divider between N_REQ requesters, round-robin.
// Define DIV_TIMEOUT_EN to add the result watchdog and the res_timeout port.
module div_share_arb
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEFAULT
`ifdef DIV_TIMEOUT_EN
    ,
    parameter int TO_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*DW-1:0] op_a,
    input  logic [N_REQ*DW-1:0] op_b,
    output logic [N_REQ-1:0]  done,
    output logic [DW-1:0]     res_data,
    output logic              res_err,
    output logic              busy,
    output logic              div_valid_in,
    output logic [DW-1:0]     div_d_in,
    output logic              div_reset,
    input  logic              div_valid_out,
    input  logic [DW-1:0]     div_d_out,
    input  logic              div_error_out
`ifdef DIV_TIMEOUT_EN
    ,
    output logic              res_timeout
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [N_REQ-1:0] gnt_q;
    logic [DW-1:0]    b_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] cnt;

    // The watchdog resets the divider for the single TO_RST cycle.
    assign div_reset = reset | (state == TO_RST);
`else
    assign div_reset = reset;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            gidx         <= '0;
            gnt_q        <= '0;
            b_q          <= '0;
            done         <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            div_valid_in <= 1'b0;
            div_d_in     <= '0;
`ifdef DIV_TIMEOUT_EN
            cnt          <= '0;
            res_timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gidx         <= arb_idx;
                        gnt_q        <= arb_gnt;
                        b_q          <= op_b[arb_idx*DW +: DW];
                        // The a operand is latched straight into the divider beat register.
                        div_d_in     <= op_a[arb_idx*DW +: DW];
                        div_valid_in <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SEND_A;
                    end
                end
                SEND_A: begin
                    div_d_in <= b_q;
                    state    <= SEND_B;
                end
                SEND_B: begin
                    div_valid_in <= 1'b0;
                    div_d_in     <= '0;
`ifdef DIV_TIMEOUT_EN
                    cnt          <= '0;
`endif
                    state        <= WAIT;
                end
                WAIT: begin
                    if (div_valid_out) begin
                        res_data <= div_d_out;
                        res_err  <= (div_error_out == DIV_BY_ZERO);
                        done     <= gnt_q;
                        state    <= RESP;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (cnt == CW'(TO_CYC - 1)) begin
                        state <= TO_RST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
`ifdef DIV_TIMEOUT_EN
                TO_RST: begin
                    res_err     <= 1'b1;
                    res_data    <= '0;
                    res_timeout <= 1'b1;
                    done        <= gnt_q;
                    state       <= RESP;
                end
`endif
                RESP: begin
                    // Also serves as the divider's required idle cycle after a result.
                    done  <= '0;
                    busy  <= 1'b0;
                    ptr   <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
`ifdef DIV_TIMEOUT_EN
                    res_timeout <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with a behavioural two-beat divider stub.
// Build with DIV_TIMEOUT_EN to also exercise the watchdog path.
module tb_div_share_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   done;
    logic [W-1:0]   res_data;
    logic           res_err;
    logic           busy;
    logic           div_valid_in;
    logic [W-1:0]   div_d_in;
    logic           div_reset;
    logic           div_valid_out = 1'b0;
    logic [W-1:0]   div_d_out = '0;
    logic           div_error_out = 1'b0;
`ifdef DIV_TIMEOUT_EN
    logic           res_timeout;
`endif

    div_share_arb #(.N_REQ(N), .DW(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .op_a          (op_a),
        .op_b          (op_b),
        .done          (done),
        .res_data      (res_data),
        .res_err       (res_err),
        .busy          (busy),
        .div_valid_in  (div_valid_in),
        .div_d_in      (div_d_in),
        .div_reset     (div_reset),
        .div_valid_out (div_valid_out),
        .div_d_out     (div_d_out),
        .div_error_out (div_error_out)
`ifdef DIV_TIMEOUT_EN
        ,
        .res_timeout   (res_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Divider stub: dividend beat, divisor beat, result strobe the next cycle.
    // With stall set it swallows the operands and never answers.
    logic       stall = 1'b0;
    logic       beat = 1'b0;
    logic [W-1:0] ma = '0;

    always @(posedge clk) begin
        div_valid_out <= 1'b0;
        if (div_reset) begin
            beat <= 1'b0;
        end else if (div_valid_in) begin
            if (!beat) begin
                ma   <= div_d_in;
                beat <= 1'b1;
            end else begin
                beat <= 1'b0;
                if (!stall) begin
                    div_valid_out <= 1'b1;
                    if (div_d_in == '0) begin
                        div_error_out <= 1'b1;
                        div_d_out     <= 4'hF;
                    end else begin
                        div_error_out <= 1'b0;
                        div_d_out     <= W'($signed(ma) / $signed(div_d_in));
                    end
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from requester idx; checks both operand beats, latency and result.
    task automatic run_single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_q, input logic exp_e, input string tag);
        int nb;
        int t0;
        int t_done;
        logic [W-1:0] a_s;
        logic [W-1:0] b_s;
        nb = 0;
        t0 = 0;
        t_done = -1;
        a_s = '0;
        b_s = '0;
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
        req[idx] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (div_valid_in) begin
                if (nb == 0) begin
                    a_s = div_d_in;
                    t0  = c;
                end else if (nb == 1) begin
                    b_s = div_d_in;
                end
                nb++;
            end
            if (done != '0) begin
                t_done = c;
                check({tag, " done"}, 32'(done), 32'(1 << idx));
                check({tag, " res_data"}, 32'(res_data), 32'(exp_q));
                check({tag, " res_err"}, 32'(res_err), 32'(exp_e));
                check({tag, " busy@done"}, 32'(busy), 32'd1);
`ifdef DIV_TIMEOUT_EN
                check({tag, " res_timeout"}, 32'(res_timeout), 32'd0);
`endif
                req[idx] = 1'b0;
                break;
            end
        end
        check({tag, " beats"}, 32'(nb), 32'd2);
        check({tag, " beat a"}, 32'(a_s), 32'(a));
        check({tag, " beat b"}, 32'(b_s), 32'(b));
        check({tag, " latency"}, 32'(t_done - t0), 32'd3);
        step();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    logic [W-1:0] exp_all [4] = '{4'hC, 4'h2, 4'h1, 4'h0};

    initial begin
        int nb;
        int any_done;
        int k;
        int prev;

        reset = 1'b1;
        step();
        step();
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid_in", 32'(div_valid_in), 32'd0);
        check("rst d_in", 32'(div_d_in), 32'd0);
        check("rst res_data", 32'(res_data), 32'd0);
        check("rst res_err", 32'(res_err), 32'd0);
        check("rst div_reset", 32'(div_reset), 32'd1);
        reset = 1'b0;
        #1;
        check("div_reset low", 32'(div_reset), 32'd0);

        run_single(0, 4'd7, 4'd2, 4'd3, 1'b0, "pos");
        run_single(1, 4'hA, 4'd2, 4'hD, 1'b0, "neg");
        run_single(2, 4'd5, 4'd0, 4'hF, 1'b1, "div0");

        // Reset while the divider is withholding its result.
        stall = 1'b1;
        op_a[3*W +: W] = 4'd6;
        op_b[3*W +: W] = 4'd2;
        req[3] = 1'b1;
        nb = 0;
        any_done = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (div_valid_in) nb++;
            if (done != '0) any_done = 1;
        end
        check("stall beats", 32'(nb), 32'd2);
        check("stall busy", 32'(busy), 32'd1);
        check("stall no done", 32'(any_done), 32'd0);
        reset = 1'b1;
        step();
        check("mid done", 32'(done), 32'd0);
        check("mid busy", 32'(busy), 32'd0);
        check("mid valid_in", 32'(div_valid_in), 32'd0);
        check("mid res_data", 32'(res_data), 32'd0);
        check("mid res_err", 32'(res_err), 32'd0);
        check("mid div_reset", 32'(div_reset), 32'd1);
        reset = 1'b0;
        stall = 1'b0;
        run_single(3, 4'd6, 4'd2, 4'd3, 1'b0, "rearm");

        // All four requesters from reset: served 0,1,2,3 every 5 cycles.
        reset = 1'b1;
        step();
        op_a = {4'd0, 4'd1, 4'd6, 4'd8};
        op_b = {4'd5, 4'd1, 4'd3, 4'd2};
        req = 4'hF;
        reset = 1'b0;
        k = 0;
        prev = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done != '0) begin
                check($sformatf("all done%0d", k), 32'(done), 32'(1 << k));
                check($sformatf("all data%0d", k), 32'(res_data), 32'(exp_all[k]));
                check($sformatf("all err%0d", k), 32'(res_err), 32'd0);
                if (k > 0) check($sformatf("all gap%0d", k), 32'(c - prev), 32'd5);
                prev = c;
                req = req & ~done;
                k++;
                if (k == 4) break;
            end
        end
        check("all served", 32'(k), 32'd4);

`ifdef DIV_TIMEOUT_EN
        begin
            int t1;
            int tr;
            int got_done;
            step();
            stall = 1'b1;
            op_a[0 +: W] = 4'd3;
            op_b[0 +: W] = 4'd1;
            req[0] = 1'b1;
            nb = 0;
            t1 = 0;
            tr = -1;
            got_done = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (div_valid_in) begin
                    nb++;
                    if (nb == 2) t1 = c;
                end
                if (div_reset && tr < 0) tr = c;
                if (done != '0) begin
                    got_done = 1;
                    check("to done", 32'(done), 32'd1);
                    check("to res_err", 32'(res_err), 32'd1);
                    check("to res_timeout", 32'(res_timeout), 32'd1);
                    check("to res_data", 32'(res_data), 32'd0);
                    req[0] = 1'b0;
                    break;
                end
            end
            check("to got_done", 32'(got_done), 32'd1);
            check("to wd delay", 32'(tr - t1), 32'(TO + 1));
            stall = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
